fp16_operand_deserializer: RTL

Receiving end of the byte-serial operand interface of the logarithmic FP16 multiplier.
- The host transmits each 16-bit operand pair as BEATS 8-bit beats, LSB byte first: A on the dedicated-input byte, B on the bidirectional-input byte.
- This block assembles the beats into complete op_a/op_b words and hands them to the multiplier core over a valid/ready handshake.
- One completed frame can be held at the output while the next frame is collected.

---
 rtl/fp16_operand_deserializer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fp16_operand_deserializer.sv
// Byte-serial operand deserializer for the logarithmic FP16 multiplier.
// Collects BEATS byte-wide beats (LSB byte first) of operands A and B into
// WIDTH-bit words and presents them to the core over a valid/ready handshake.
// One completed frame can sit in the output register while the next frame
// is being assembled.
// Optional: define FP_DESER_TIMEOUT_EN to drop partial frames that go idle
// for TIMEOUT_CYCLES cycles, pulsing `timeout` when that happens.
module fp16_operand_deserializer #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned BEATS          = WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a_byte,
  input  logic [7:0]       b_byte,
  input  logic             sync,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [7:0]       frame_cnt,
  output logic             timeout
);

  localparam int unsigned CntW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

  // Reject configurations the beat/byte mapping cannot represent.
  if (WIDTH % 8 != 0 || WIDTH == 0 || BEATS != WIDTH / 8 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("fp16_operand_deserializer: invalid WIDTH/BEATS/TIMEOUT_CYCLES");
  end

  logic [CntW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [WIDTH-1:0] asm_a_q, asm_a_d;
  logic [WIDTH-1:0] asm_b_q, asm_b_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  logic             beat_acc;
  logic             last_beat;
  logic [WIDTH-1:0] asm_a_new;
  logic [WIDTH-1:0] asm_b_new;
  logic             drop;

  // Only the final beat can stall: it needs the output register free or draining.
  always_comb begin
    last_beat = (beat_cnt_q == LastBeat);
    in_ready  = !(last_beat && out_valid_q && !out_ready);
    beat_acc  = in_valid && in_ready && !sync;
  end

  // Merge the current beat's bytes into the assembly words.
  always_comb begin
    asm_a_new = asm_a_q;
    asm_b_new = asm_b_q;
    asm_a_new[8 * int'(beat_cnt_q) +: 8] = a_byte;
    asm_b_new[8 * int'(beat_cnt_q) +: 8] = b_byte;
  end

`ifdef FP_DESER_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

  logic [IdleW-1:0] idle_q, idle_d;
  logic             timeout_q, timeout_d;

  // Count idle cycles inside a partial frame; expire after TIMEOUT_CYCLES.
  always_comb begin
    idle_d    = idle_q;
    timeout_d = 1'b0;
    drop      = 1'b0;
    if (sync || beat_acc || beat_cnt_q == '0) begin
      idle_d = '0;
    end else if (idle_q == IdleW'(TIMEOUT_CYCLES - 1)) begin
      idle_d    = '0;
      timeout_d = 1'b1;
      drop      = 1'b1;
    end else begin
      idle_d = idle_q + 1'b1;
    end
  end

  // Idle counter and timeout pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign drop    = 1'b0;
  assign timeout = 1'b0;
`endif

  // Beat counter, assembly and output register next state.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    asm_a_d     = asm_a_q;
    asm_b_d     = asm_b_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    out_valid_d = out_valid_q;
    frame_cnt_d = frame_cnt_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (sync) begin
      beat_cnt_d = '0;
    end else if (beat_acc) begin
      if (last_beat) begin
        // Final beat goes straight to the output; a same-cycle drain is overwritten.
        op_a_d      = asm_a_new;
        op_b_d      = asm_b_new;
        out_valid_d = 1'b1;
        frame_cnt_d = frame_cnt_q + 8'd1;
        beat_cnt_d  = '0;
      end else begin
        asm_a_d    = asm_a_new;
        asm_b_d    = asm_b_new;
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end else if (drop) begin
      beat_cnt_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      asm_a_q     <= '0;
      asm_b_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      out_valid_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      asm_a_q     <= asm_a_d;
      asm_b_q     <= asm_b_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      out_valid_q <= out_valid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign out_valid = out_valid_q;
  assign frame_cnt = frame_cnt_q;

endmodule
